// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter: p_REQUESTERS producers share one sync_fifo write port.
// Optional macro ALMOST_FULL_THROTTLE_EN: almost-full also blocks new grants from IDLE.
module fifo_write_arbiter #(
  parameter int unsigned p_REQUESTERS   = 4,
  parameter int unsigned p_DATA_WIDTH   = 8,
  parameter int unsigned p_BURST_LENGTH = 4
) (
  input  logic                                 i_CLK,
  input  logic                                 i_RESET,
  input  logic [p_REQUESTERS-1:0]              i_REQUEST,
  input  logic [p_REQUESTERS*p_DATA_WIDTH-1:0] i_DATA,
  input  logic                                 i_FIFO_FULL,
  input  logic                                 i_FIFO_ALMOST_FULL,
  output logic [p_REQUESTERS-1:0]              o_GRANT,
  output logic [p_REQUESTERS-1:0]              o_ACK,
  output logic                                 o_WRITE_REQUEST,
  output logic [p_DATA_WIDTH-1:0]              o_WRITE_DATA,
  output logic                                 o_BUSY
);

  localparam int unsigned IDX_W = (p_REQUESTERS > 1) ? $clog2(p_REQUESTERS) : 1;
  localparam int unsigned CNT_W = $clog2(p_BURST_LENGTH) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [p_REQUESTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]        last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;

  logic                    blocked_c;
  logic                    win_found_c;
  logic [IDX_W-1:0]        win_idx_c;
  logic                    req_g_c;
  logic                    write_c;
  logic [p_DATA_WIDTH-1:0] data_c;

`ifdef ALMOST_FULL_THROTTLE_EN
  assign blocked_c = i_FIFO_FULL | i_FIFO_ALMOST_FULL;
`else
  logic unused_almost_full;
  assign unused_almost_full = i_FIFO_ALMOST_FULL;
  assign blocked_c          = i_FIFO_FULL;
`endif

  // Round-robin search starting one past the last winner, wrapping.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = last_q;
    for (int unsigned i = 1; i <= p_REQUESTERS; i++) begin
      if (!win_found_c && i_REQUEST[IDX_W'((32'(last_q) + i) % p_REQUESTERS)]) begin
        win_found_c = 1'b1;
        win_idx_c   = IDX_W'((32'(last_q) + i) % p_REQUESTERS);
      end
    end
  end

  // Write path; grant_q is zero in IDLE, which zeroes data and request there.
  always_comb begin
    req_g_c = |(i_REQUEST & grant_q);
    write_c = (state_q == ST_BURST) && req_g_c && !i_FIFO_FULL;
    data_c  = '0;
    for (int unsigned k = 0; k < p_REQUESTERS; k++) begin
      if (grant_q[k]) begin
        data_c = data_c | i_DATA[k*p_DATA_WIDTH +: p_DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found_c && !blocked_c) begin
          state_d = ST_BURST;
          grant_d = p_REQUESTERS'(1'b1) << win_idx_c;
          last_d  = win_idx_c;
          cnt_d   = '0;
        end
      end
      ST_BURST: begin
        // A dropped request releases even if this would have been the last word.
        if (!req_g_c) begin
          state_d = ST_IDLE;
          grant_d = '0;
          cnt_d   = '0;
        end else if (write_c) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(p_BURST_LENGTH)) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(p_REQUESTERS - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign o_GRANT         = grant_q;
  assign o_BUSY          = busy_q;
  assign o_WRITE_REQUEST = write_c;
  assign o_ACK           = write_c ? grant_q : '0;
  assign o_WRITE_DATA    = data_c;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural round-robin burst model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BL = 4;

  logic           clk   = 1'b0;
  logic           rst   = 1'b1;
  logic [N-1:0]   req   = '0;
  logic [N*W-1:0] din   = '0;
  logic           full  = 1'b0;
  logic           afull = 1'b0;
  logic [N-1:0]   o_grant, o_ack;
  logic           o_wr, o_busy;
  logic [W-1:0]   o_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit m_busy = 1'b0;
  int m_g    = 0;
  int m_last = N - 1;
  int m_cnt  = 0;

  logic [N-1:0] gseq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  fifo_write_arbiter #(
    .p_REQUESTERS  (N),
    .p_DATA_WIDTH  (W),
    .p_BURST_LENGTH(BL)
  ) dut (
    .i_CLK             (clk),
    .i_RESET           (rst),
    .i_REQUEST         (req),
    .i_DATA            (din),
    .i_FIFO_FULL       (full),
    .i_FIFO_ALMOST_FULL(afull),
    .o_GRANT           (o_grant),
    .o_ACK             (o_ack),
    .o_WRITE_REQUEST   (o_wr),
    .o_WRITE_DATA      (o_wdata),
    .o_BUSY            (o_busy)
  );

  always #5 clk = ~clk;

  function automatic logic bit_at(input logic [N-1:0] v, input int k);
    logic [N-1:0] t;
    t = v >> k;
    return t[0];
  endfunction

  function automatic logic [W-1:0] slice(input logic [N*W-1:0] v, input int k);
    return W'(v >> (k * W));
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (bit_at(r, (last + i) % N)) return (last + i) % N;
    end
    return 0;
  endfunction

  function automatic logic is_blocked();
`ifdef ALMOST_FULL_THROTTLE_EN
    return full | afull;
`else
    return full;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: grant rules applied per edge, reset asynchronous.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_g    <= 0;
      m_last <= N - 1;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (req != '0 && !is_blocked()) begin
        m_busy <= 1'b1;
        m_g    <= pick(req, m_last);
        m_last <= pick(req, m_last);
        m_cnt  <= 0;
      end
    end else if (!bit_at(req, m_g)) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!full) begin
      if (m_cnt + 1 == BL) begin
        m_busy <= 1'b0;
        m_cnt  <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin : cmp
    logic [N-1:0] eg;
    logic         ew;
    logic [W-1:0] ed;
    eg = m_busy ? (N'(1) << m_g) : '0;
    ew = m_busy && bit_at(req, m_g) && !full;
    ed = m_busy ? slice(din, m_g) : '0;
    chk("m_grant", 32'(o_grant), 32'(eg));
    chk("m_wreq",  32'(o_wr),    32'(ew));
    chk("m_ack",   32'(o_ack),   32'(ew ? eg : '0));
    chk("m_wdata", 32'(o_wdata), 32'(ed));
    chk("m_busy",  32'(o_busy),  32'(m_busy));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Reset for one edge, check reset outputs, leave at start of cycle 0.
  task automatic do_reset();
    rst = 1'b1; req = '0; full = 1'b0; afull = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(o_grant), 32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk("rst_wreq",  32'(o_wr),    32'd0);
    chk("rst_wdata", 32'(o_wdata), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int acks;
    logic [N-1:0] eg;

    // All four requesting: rotating grants, 4 ACKs each, one idle cycle between.
    do_reset();
    req  = 4'b1111;
    acks = 0;
    for (int c = 0; c < 25; c++) begin
      din = $urandom;
      @(negedge clk);
      eg = (c % 5 == 0) ? 4'b0000 : gseq[c / 5];
      chk("t1_grant", 32'(o_grant), 32'(eg));
      if (o_ack != '0) acks++;
      next();
    end
    chk("t1_acks", 32'(acks), 32'd20);

    // Producer 2 alone with constant data.
    do_reset();
    req  = 4'b0100;
    din  = 32'h00A5_0000;
    acks = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("t2_grant", 32'(o_grant), 32'h4);
        chk("t2_data",  32'(o_wdata), 32'hA5);
      end
      if (c == 5) chk("t2_idle", 32'(o_grant), 32'h0);
      if (c == 6) chk("t2_regrant", 32'(o_grant), 32'h4);
      if (c <= 5 && o_wr && o_wdata == 8'hA5) acks++;
      next();
    end
    chk("t2_writes", 32'(acks), 32'd4);

    // FIFO full for 3 cycles after the second write of producer 1.
    do_reset();
    req  = 4'b0010;
    acks = 0;
    for (int c = 0; c < 9; c++) begin
      full = (c >= 3 && c <= 5);
      @(negedge clk);
      if (c >= 3 && c <= 5) begin
        chk("t3_stall_wr", 32'(o_wr),    32'd0);
        chk("t3_hold_gnt", 32'(o_grant), 32'h2);
      end
      if (c == 8) chk("t3_release", 32'(o_grant), 32'h0);
      if (o_ack != '0) acks++;
      next();
    end
    full = 1'b0;
    chk("t3_acks", 32'(acks), 32'd4);

    // Producer 0 drops after two ACKs; producer 1 is next.
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) req = 4'b0010;
      @(negedge clk);
      if (c == 1 || c == 2) chk("t4_ack0", 32'(o_ack), 32'h1);
      if (c == 3) begin
        chk("t4_drop_gnt", 32'(o_grant), 32'h1);
        chk("t4_drop_wr",  32'(o_wr),    32'd0);
      end
      if (c == 4) chk("t4_idle", 32'(o_grant), 32'h0);
      if (c == 5) chk("t4_next", 32'(o_grant), 32'h2);
      next();
    end

    // Reset pulsed mid-burst clears grant and write request immediately.
    do_reset();
    req = 4'b1111;
    @(negedge clk);
    next();
    @(negedge clk);
    chk("t5_pre_gnt", 32'(o_grant), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_gnt", 32'(o_grant), 32'h0);
    chk("t5_rst_wr",  32'(o_wr),    32'd0);
    chk("t5_rst_ack", 32'(o_ack),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(o_grant), 32'h0);
    next();
    @(negedge clk);
    chk("t5_regrant", 32'(o_grant), 32'h1);
    next();

    // Almost-full in IDLE: throttles only when the macro is defined.
    do_reset();
    afull = 1'b1;
    req   = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) afull = 1'b0;
      @(negedge clk);
`ifdef ALMOST_FULL_THROTTLE_EN
      if (c >= 1 && c <= 4) chk("t6_throttle", 32'(o_grant), 32'h0);
      if (c == 5) chk("t6_after", 32'(o_grant), 32'h1);
`else
      if (c >= 1 && c <= 4) chk("t6_nothrottle", 32'(o_grant), 32'h1);
      if (c == 5) chk("t6_after", 32'(o_grant), 32'h0);
`endif
      next();
    end
    afull = 1'b0;

    // Randomized traffic, checked by the per-cycle model comparison.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      else if ($urandom_range(0, 7) == 0) req = req & N'($urandom);
      din   = $urandom;
      full  = ($urandom_range(0, 4) == 0);
      afull = ($urandom_range(0, 3) == 0);
      rst   = ($urandom_range(0, 149) == 0);
      next();
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
